dot8_seq: RTL and testbench

DOT8_SEQ -- requirements
Module: dot8_seq

---
 rtl/dot8_seq.sv | 196 +++++++++++++++++++
 tb/tb_dot8_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dot8_seq.sv
// Sequential float8 dot product: streams N operand pairs from two memories
// through one Float8Mult and accumulates the products in Q12.7 fixed point.

module Float8Mult (
    input  logic [7:0] iNum1,
    input  logic [7:0] iNum2,
    output logic [7:0] oNum,
    output logic       overflow
);
    logic [9:0] mProd;
    logic       norm;
    logic [3:0] mant;
    logic [4:0] eSum;

    // Truncating multiply; results below the smallest normal flush to zero
    always_comb begin
        oNum     = 8'h00;
        overflow = 1'b0;
        mProd    = 10'({1'b1, iNum1[3:0]}) * 10'({1'b1, iNum2[3:0]});
        norm     = mProd[9];
        mant     = norm ? mProd[8:5] : mProd[7:4];
        eSum     = 5'(iNum1[6:4]) + 5'(iNum2[6:4]) + 5'(norm);
        if ((iNum1[6:4] != 3'd0) && (iNum2[6:4] != 3'd0)) begin
            if (eSum > 5'd11) begin
                overflow = 1'b1;
                oNum     = {iNum1[7] ^ iNum2[7], 7'h7F};
            end else if (eSum >= 5'd5) begin
                oNum = {iNum1[7] ^ iNum2[7], 3'(eSum - 5'd4), mant};
            end
        end
    end
endmodule

module dot8_seq #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [7:0]        iLen,
    input  logic [ADDR_W-1:0] iBaseA,
    input  logic [ADDR_W-1:0] iBaseB,
    output logic              oRdEn,
    output logic [ADDR_W-1:0] oAddrA,
    output logic [ADDR_W-1:0] oAddrB,
    input  logic [7:0]        iDataA,
    input  logic [7:0]        iDataB,
    output logic              oBusy,
    output logic              oDone,
    output logic [19:0]       oResult,
    output logic              oOverflow
);
    localparam int unsigned ACC_W = 20;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext, cntInc;
    logic [CNT_W-1:0]  lenM1, lenM1Next;
    logic [ADDR_W-1:0] baseA, baseANext, baseB, baseBNext;
    logic [ADDR_W-1:0] addrANext, addrBNext;
    logic              rdEnNext, busyNext, doneNext, clrAcc;

    logic [7:0]              mulNum;
    logic                    mulOvf;
    logic                    rdEnD, prodVld, prodOvf;
    logic [7:0]              prodReg;
    logic signed [ACC_W-1:0] acc, term;
    logic                    ovfSticky;

    Float8Mult uMult (
        .iNum1    (iDataA),
        .iNum2    (iDataB),
        .oNum     (mulNum),
        .overflow (mulOvf)
    );

    function automatic logic signed [ACC_W-1:0] toFixed(input logic [7:0] f);
        logic [ACC_W-1:0] mag;
        mag = ACC_W'({1'b1, f[3:0]}) << (f[6:4] - 3'd1);
        if (f[6:4] == 3'd0) return '0;
        return f[7] ? -mag : mag;
    endfunction

    assign cntInc = cnt + CNT_W'(1);
    assign term   = toFixed(prodReg);

    // Next-state and next-output logic
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        lenM1Next = lenM1;
        baseANext = baseA;
        baseBNext = baseB;
        rdEnNext  = 1'b0;
        addrANext = '0;
        addrBNext = '0;
        clrAcc    = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    stateNext = RUN;
                    lenM1Next = iLen - CNT_W'(1);
                    baseANext = iBaseA;
                    baseBNext = iBaseB;
                    cntNext   = '0;
                    rdEnNext  = 1'b1;
                    addrANext = iBaseA;
                    addrBNext = iBaseB;
                    clrAcc    = 1'b1;
                end
            end
            RUN: begin
                if (cnt == lenM1) begin
                    stateNext = DRAIN;
                    cntNext   = '0;
                end else begin
                    cntNext   = cntInc;
                    rdEnNext  = 1'b1;
                    addrANext = baseA + ADDR_W'(cntInc);
                    addrBNext = baseB + ADDR_W'(cntInc);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(1)) begin
                    stateNext = DONE;
                    cntNext   = '0;
                end else begin
                    cntNext = cntInc;
                end
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext != IDLE);
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            lenM1  <= '0;
            baseA  <= '0;
            baseB  <= '0;
            oRdEn  <= 1'b0;
            oAddrA <= '0;
            oAddrB <= '0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            lenM1  <= lenM1Next;
            baseA  <= baseANext;
            baseB  <= baseBNext;
            oRdEn  <= rdEnNext;
            oAddrA <= addrANext;
            oAddrB <= addrBNext;
            oBusy  <= busyNext;
            oDone  <= doneNext;
        end
    end

    // Product register (data arrives one cycle after the read) and accumulator
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rdEnD     <= 1'b0;
            prodVld   <= 1'b0;
            prodReg   <= '0;
            prodOvf   <= 1'b0;
            acc       <= '0;
            ovfSticky <= 1'b0;
        end else begin
            rdEnD   <= oRdEn;
            prodVld <= rdEnD;
            if (rdEnD) begin
                prodReg <= mulNum;
                prodOvf <= mulOvf;
            end
            if (clrAcc) begin
                acc       <= '0;
                ovfSticky <= 1'b0;
            end else if (prodVld) begin
                if (prodOvf) ovfSticky <= 1'b1;
                else         acc       <= acc + term;
            end
        end
    end

    assign oResult   = acc;
    assign oOverflow = ovfSticky;
endmodule

// File: tb/tb_dot8_seq.sv
// Bench for dot8_seq: operand memories, real-valued float8 reference model,
// directed scenarios plus randomized runs.

module tb_dot8_seq;
    logic       clk = 1'b0;
    logic       iRst_n;
    logic       iStart;
    logic [7:0] iLen;
    logic [7:0] iBaseA, iBaseB;
    logic       oRdEn;
    logic [7:0] oAddrA, oAddrB;
    logic [7:0] iDataA, iDataB;
    logic       oBusy, oDone;
    logic [19:0] oResult;
    logic       oOverflow;

    logic [7:0] memA [256];
    logic [7:0] memB [256];
    int nAsserts = 0;
    int nFails   = 0;

    dot8_seq #(.ADDR_W(8)) dut (
        .iClk(clk), .iRst_n(iRst_n), .iStart(iStart), .iLen(iLen),
        .iBaseA(iBaseA), .iBaseB(iBaseB), .oRdEn(oRdEn), .oAddrA(oAddrA),
        .oAddrB(oAddrB), .iDataA(iDataA), .iDataB(iDataB), .oBusy(oBusy),
        .oDone(oDone), .oResult(oResult), .oOverflow(oOverflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; memories answer a read strobe with data in the following cycle
    task automatic step();
        logic       en;
        logic [7:0] aA, aB;
        en = oRdEn; aA = oAddrA; aB = oAddrB;
        @(posedge clk);
        #1;
        iDataA = en ? memA[aA] : 8'h00;
        iDataB = en ? memB[aB] : 8'h00;
    endtask

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    // Exact real product, re-rounded (truncated) into float8, then scaled by 2^7
    function automatic int refTerm(input logic [7:0] a, input logic [7:0] b, output bit ovf);
        real va, vb, v, frac;
        int  e, m, be, mag;
        ovf = 1'b0;
        if (a[6:4] == 3'd0 || b[6:4] == 3'd0) return 0;
        va = (1.0 + real'(int'(a[3:0])) / 16.0) * pow2(int'(a[6:4]) - 4);
        vb = (1.0 + real'(int'(b[3:0])) / 16.0) * pow2(int'(b[6:4]) - 4);
        v  = va * vb;
        e  = 0;
        while (v >= pow2(e + 1)) e++;
        while (v < pow2(e)) e--;
        frac = v / pow2(e);
        m    = $rtoi((frac - 1.0) * 16.0);
        be   = e + 4;
        if (be > 7) begin
            ovf = 1'b1;
            return 0;
        end
        if (be < 1) return 0;
        mag = (16 + m) * (1 << (be - 1));
        return (a[7] ^ b[7]) ? -mag : mag;
    endfunction

    function automatic void modelRun(input logic [7:0] len, input logic [7:0] bA,
                                     input logic [7:0] bB, output int sum, output bit ovf);
        int  n;
        bit  o;
        logic [7:0] ia, ib;
        n = (len == 8'd0) ? 256 : int'(len);
        sum = 0; ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            ia = bA + 8'(i);
            ib = bB + 8'(i);
            sum += refTerm(memA[ia], memB[ib], o);
            ovf |= o;
        end
    endfunction

    task automatic runDot(input logic [7:0] len, input logic [7:0] bA, input logic [7:0] bB,
                          input bit pulse, input int expRes, input bit expOvf);
        int n;
        logic       en;
        logic [7:0] eA, eB;
        n = (len == 8'd0) ? 256 : int'(len);
        iStart = 1'b1; iLen = len; iBaseA = bA; iBaseB = bB;
        step();
        for (int k = 1; k <= n + 4; k++) begin
            en = (k <= n);
            eA = en ? bA + 8'(k - 1) : 8'h00;
            eB = en ? bB + 8'(k - 1) : 8'h00;
            check($sformatf("ctrl k=%0d", k),
                  {13'b0, oRdEn, oAddrA, oAddrB, oBusy, oDone},
                  {13'b0, en, eA, eB, 1'(k <= n + 3), 1'(k == n + 3)});
            if (k >= n + 3) begin
                check("result", 32'($signed(oResult)), 32'(expRes));
                check("overflow", 32'(oOverflow), 32'(expOvf));
            end
            if (k == 1) begin
                iStart = 1'b0;
                iLen   = 8'($urandom);
                iBaseA = 8'($urandom);
                iBaseB = 8'($urandom);
            end
            if (pulse && k == 2) iStart = 1'b1;
            if (pulse && k == 3) iStart = 1'b0;
            step();
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 256; i++) begin
            memA[i] = 8'($urandom);
            memB[i] = 8'($urandom);
        end
    endtask

    initial begin
        int  sum;
        bit  ovf;
        logic [7:0] len, bA, bB;
        iRst_n = 1'b0; iStart = 1'b0; iLen = 8'h00; iBaseA = 8'h00; iBaseB = 8'h00;
        iDataA = 8'h00; iDataB = 8'h00;
        for (int i = 0; i < 256; i++) begin memA[i] = 8'h00; memB[i] = 8'h00; end
        repeat (3) @(posedge clk);
        #1;
        check("reset ctrl", {13'b0, oRdEn, oAddrA, oAddrB, oBusy, oDone}, 32'h0);
        check("reset result", {11'b0, oOverflow, oResult}, 32'h0);
        iRst_n = 1'b1;
        step(); step();

        // 1.0 * 1.0
        memA[8'h10] = 8'h40; memB[8'h10] = 8'h40;
        runDot(8'd1, 8'h10, 8'h10, 1'b0, 128, 1'b0);

        // 4 x (2.0 * 0.5), with a start re-pulse mid-run that must be ignored
        for (int i = 0; i < 4; i++) begin memA[8'h20 + i] = 8'h50; memB[8'h60 + i] = 8'h30; end
        runDot(8'd4, 8'h20, 8'h60, 1'b1, 512, 1'b0);

        memA[0] = 8'h40; memA[1] = 8'hC0; memB[8'h80] = 8'h40; memB[8'h81] = 8'h40;
        runDot(8'd2, 8'h00, 8'h80, 1'b0, 0, 1'b0);
        memA[0] = 8'h00; memA[1] = 8'h40; memB[8'h80] = 8'hB3; memB[8'h81] = 8'h40;
        runDot(8'd2, 8'h00, 8'h80, 1'b0, 128, 1'b0);

        // Overflowing product contributes nothing but sets the sticky flag
        memA[8'h30] = 8'h7F; memA[8'h31] = 8'h40; memB[8'h30] = 8'h50; memB[8'h31] = 8'h40;
        runDot(8'd2, 8'h30, 8'h30, 1'b0, 128, 1'b1);

        // Full 256-term run with address wrap
        for (int i = 0; i < 256; i++) begin memA[i] = 8'h40; memB[i] = 8'h40; end
        runDot(8'd0, 8'hF0, 8'h37, 1'b0, 32768, 1'b0);

        // Randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            fillRandom();
            len = (r == 5) ? 8'($urandom_range(60, 120)) : 8'($urandom_range(1, 20));
            bA  = 8'($urandom);
            bB  = 8'($urandom);
            modelRun(len, bA, bB, sum, ovf);
            runDot(len, bA, bB, 1'(r % 2), sum, ovf);
        end

        // Reset mid-run: outputs clear at once and the run never completes
        fillRandom();
        iStart = 1'b1; iLen = 8'd10; iBaseA = 8'h05; iBaseB = 8'h09;
        step();
        iStart = 1'b0;
        step();
        iRst_n = 1'b0;
        #1;
        check("midrun reset ctrl", {13'b0, oRdEn, oAddrA, oAddrB, oBusy, oDone}, 32'h0);
        check("midrun reset result", {11'b0, oOverflow, oResult}, 32'h0);
        step(); step();
        iRst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            check("post-reset idle", {30'b0, oBusy, oDone}, 32'h0);
        end

        // Clean run after the abort
        len = 8'd13; bA = 8'hFA; bB = 8'h41;
        modelRun(len, bA, bB, sum, ovf);
        runDot(len, bA, bB, 1'b0, sum, ovf);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
